// File: rtl/cpu_single_cycle.sv
// Single-cycle 32-bit MIPS-subset core: PC, instruction ROM, register file,
// ALU, data memory and decode all resolve within one clock.

module cpu_single_cycle_im #(
  parameter int IM_WORDS = 256,
  parameter int AW       = 8
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);
  // Contents are loaded hierarchically before reset release.
  logic [31:0] memory [0:IM_WORDS-1];

  assign data = memory[addr];
endmodule

module cpu_single_cycle_rf (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [0:31];

  // regs[0] is only ever cleared, so $0 reads as zero without a read mux.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

  logic [31:0] contents_zero, contents_at, contents_v0, contents_v1;
  logic [31:0] contents_a0, contents_a1, contents_a2, contents_a3;
  logic [31:0] contents_t0, contents_t1, contents_t2, contents_t3;
  logic [31:0] contents_t4, contents_t5, contents_t6, contents_t7;
  logic [31:0] contents_s0, contents_s1, contents_s2, contents_s3;
  logic [31:0] contents_s4, contents_s5, contents_s6, contents_s7;
  logic [31:0] contents_t8, contents_t9, contents_k0, contents_k1;
  logic [31:0] contents_gp, contents_sp, contents_fp, contents_ra;

  assign contents_zero = regs[0];  assign contents_at = regs[1];
  assign contents_v0   = regs[2];  assign contents_v1 = regs[3];
  assign contents_a0   = regs[4];  assign contents_a1 = regs[5];
  assign contents_a2   = regs[6];  assign contents_a3 = regs[7];
  assign contents_t0   = regs[8];  assign contents_t1 = regs[9];
  assign contents_t2   = regs[10]; assign contents_t3 = regs[11];
  assign contents_t4   = regs[12]; assign contents_t5 = regs[13];
  assign contents_t6   = regs[14]; assign contents_t7 = regs[15];
  assign contents_s0   = regs[16]; assign contents_s1 = regs[17];
  assign contents_s2   = regs[18]; assign contents_s3 = regs[19];
  assign contents_s4   = regs[20]; assign contents_s5 = regs[21];
  assign contents_s6   = regs[22]; assign contents_s7 = regs[23];
  assign contents_t8   = regs[24]; assign contents_t9 = regs[25];
  assign contents_k0   = regs[26]; assign contents_k1 = regs[27];
  assign contents_gp   = regs[28]; assign contents_sp = regs[29];
  assign contents_fp   = regs[30]; assign contents_ra = regs[31];
endmodule

module cpu_single_cycle #(
  parameter int IM_WORDS = 256,
  parameter int DM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  output logic [5:0]  OPCODE,
  output logic [5:0]  FUNCTCODE,
  output logic        Overflow
);
  localparam int IAW = $clog2(IM_WORDS);
  localparam int DAW = $clog2(DM_WORDS);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07,
    OP_ADDI  = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0A, OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D, OP_XORI   = 6'h0E, OP_LUI  = 6'h0F, OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } op_t;

  typedef enum logic [5:0] {
    F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR   = 6'h08,
    F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
    F_AND = 6'h24, F_OR  = 6'h25, F_XOR = 6'h26, F_NOR  = 6'h27,
    F_SLT = 6'h2A, F_SLTU = 6'h2B
  } funct_t;

  logic [31:0] pc, instr, pc4, next_pc;
  logic [31:0] a, b, simm, zimm, br_target, j_target;
  logic [31:0] res, wd, dm_rdata;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, wa;
  logic [15:0] imm;
  logic        we, mem_we, load, ovf;
  logic [31:0] dmem [0:DM_WORDS-1];

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  assign simm      = {{16{imm[15]}}, imm};
  assign zimm      = {16'h0000, imm};
  assign pc4       = pc + 32'd4;
  assign br_target = pc4 + {simm[29:0], 2'b00};
  assign j_target  = {pc4[31:28], instr[25:0], 2'b00};

  cpu_single_cycle_im #(.IM_WORDS(IM_WORDS), .AW(IAW)) b2v_im (
    .addr (pc[IAW+1:2]),
    .data (instr)
  );

  cpu_single_cycle_rf b2v_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (a),
    .rd2   (b),
    .we    (we),
    .wa    (wa),
    .wd    (wd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= '0;
    else        pc <= next_pc;
  end

  always_comb begin
    res     = '0;
    we      = 1'b0;
    wa      = rd;
    mem_we  = 1'b0;
    load    = 1'b0;
    ovf     = 1'b0;
    next_pc = pc4;
    case (op)
      OP_RTYPE: begin
        we = 1'b1;
        case (funct)
          F_ADD:  begin
            res = a + b;
            ovf = (a[31] == b[31]) && (res[31] != a[31]);
          end
          F_ADDU: res = a + b;
          F_SUB:  begin
            res = a - b;
            ovf = (a[31] != b[31]) && (res[31] != a[31]);
          end
          F_SUBU: res = a - b;
          F_AND:  res = a & b;
          F_OR:   res = a | b;
          F_XOR:  res = a ^ b;
          F_NOR:  res = ~(a | b);
          F_SLT:  res = {31'd0, $signed(a) < $signed(b)};
          F_SLTU: res = {31'd0, a < b};
          F_SLL:  res = b << shamt;
          F_SRL:  res = b >> shamt;
          F_SRA:  res = $signed(b) >>> shamt;
          F_JR:   begin
            we      = 1'b0;
            next_pc = a;
          end
          default: we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        res = a + simm;
        ovf = (a[31] == simm[31]) && (res[31] != a[31]);
        we  = 1'b1;
        wa  = rt;
      end
      OP_ADDIU: begin res = a + simm; we = 1'b1; wa = rt; end
      OP_SLTI:  begin res = {31'd0, $signed(a) < $signed(simm)}; we = 1'b1; wa = rt; end
      OP_ANDI:  begin res = a & zimm; we = 1'b1; wa = rt; end
      OP_ORI:   begin res = a | zimm; we = 1'b1; wa = rt; end
      OP_XORI:  begin res = a ^ zimm; we = 1'b1; wa = rt; end
      OP_LUI:   begin res = {imm, 16'h0000}; we = 1'b1; wa = rt; end
      OP_LW:    begin res = a + simm; we = 1'b1; wa = rt; load = 1'b1; end
      OP_SW:    begin res = a + simm; mem_we = 1'b1; end
      OP_BEQ:   if (a == b) next_pc = br_target;
      OP_BNE:   if (a != b) next_pc = br_target;
      OP_BLEZ:  if (a[31] || a == '0) next_pc = br_target;
      OP_BGTZ:  if (!a[31] && a != '0) next_pc = br_target;
      OP_REGIMM: begin
        if (rt == 5'd0 && a[31])       next_pc = br_target;
        else if (rt == 5'd1 && !a[31]) next_pc = br_target;
      end
      OP_J:     next_pc = j_target;
      OP_JAL:   begin
        next_pc = j_target;
        res     = pc4;
        we      = 1'b1;
        wa      = 5'd31;
      end
      default: ;
    endcase
  end

  assign dm_rdata = dmem[res[DAW+1:2]];
  assign wd       = load ? dm_rdata : res;

  // Reset is in the sensitivity list only so a store cannot land while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
    end else if (mem_we) begin
      dmem[res[DAW+1:2]] <= b;
    end
  end

  assign PC        = pc;
  assign OPCODE    = op;
  assign FUNCTCODE = funct;
  assign Overflow  = ovf;
endmodule

// File: tb/tb_cpu_single_cycle.sv
// Bench for cpu_single_cycle: directed PC/flag trace tables, reset and wrap
// sequences, and random ALU/memory programs checked against a reference model.

module tb_cpu_single_cycle;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic [5:0]  OPCODE, FUNCTCODE;
  logic        Overflow;

  cpu_single_cycle #(.IM_WORDS(256), .DM_WORDS(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .PC        (PC),
    .OPCODE    (OPCODE),
    .FUNCTCODE (FUNCTCODE),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] ri(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction
  function automatic logic [31:0] ii(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction
  function automatic logic [31:0] ji(input int op, input int tgt);
    return {op[5:0], tgt[25:0]};
  endfunction

  // ---------------- directed trace tables ----------------
  typedef struct {
    logic [31:0] pc;
    logic        ovf;
    int          rsel;
    logic [31:0] rval;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] prog[$];

  task automatic av(input logic [31:0] pc, input logic ovf, input int rsel, input logic [31:0] rval);
    vec_t t;
    t.pc = pc; t.ovf = ovf; t.rsel = rsel; t.rval = rval;
    vecs.push_back(t);
  endtask

  task automatic load_prog();
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++)
      dut.b2v_im.memory[i] = (i < prog.size()) ? prog[i] : 32'h0;
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      int          idx;
      logic [31:0] w;
      idx = int'(vecs[i].pc[9:2]);
      w   = (idx < prog.size()) ? prog[idx] : 32'h0;
      check($sformatf("%s pc[%0d]", tag, i), PC, vecs[i].pc);
      check($sformatf("%s opcode[%0d]", tag, i), {26'd0, OPCODE}, {26'd0, w[31:26]});
      check($sformatf("%s funct[%0d]", tag, i), {26'd0, FUNCTCODE}, {26'd0, w[5:0]});
      check($sformatf("%s ovf[%0d]", tag, i), {31'd0, Overflow}, {31'd0, vecs[i].ovf});
      if (vecs[i].rsel != 0)
        check($sformatf("%s r%0d[%0d]", tag, vecs[i].rsel, i),
              dut.b2v_rf.regs[vecs[i].rsel], vecs[i].rval);
      @(negedge clk);
      #1;
    end
  endtask

  // ---------------- reference model for random programs ----------------
  typedef enum int {
    K_ADD, K_ADDU, K_SUB, K_SUBU, K_AND, K_OR, K_XOR, K_NOR, K_SLT, K_SLTU,
    K_SLL, K_SRL, K_SRA, K_ADDI, K_ADDIU, K_SLTI, K_ANDI, K_ORI, K_XORI,
    K_LUI, K_LW, K_SW
  } kind_t;

  typedef struct {
    kind_t k;
    int    rs, rt, rd, sh, imm;
  } rin_t;

  rin_t        rq[$];
  logic [31:0] mreg [32];
  logic [31:0] mdm  [256];

  function automatic logic [31:0] enc(input rin_t x);
    case (x.k)
      K_ADD:   return ri(x.rs, x.rt, x.rd, 0, 'h20);
      K_ADDU:  return ri(x.rs, x.rt, x.rd, 0, 'h21);
      K_SUB:   return ri(x.rs, x.rt, x.rd, 0, 'h22);
      K_SUBU:  return ri(x.rs, x.rt, x.rd, 0, 'h23);
      K_AND:   return ri(x.rs, x.rt, x.rd, 0, 'h24);
      K_OR:    return ri(x.rs, x.rt, x.rd, 0, 'h25);
      K_XOR:   return ri(x.rs, x.rt, x.rd, 0, 'h26);
      K_NOR:   return ri(x.rs, x.rt, x.rd, 0, 'h27);
      K_SLT:   return ri(x.rs, x.rt, x.rd, 0, 'h2A);
      K_SLTU:  return ri(x.rs, x.rt, x.rd, 0, 'h2B);
      K_SLL:   return ri(0, x.rt, x.rd, x.sh, 'h00);
      K_SRL:   return ri(0, x.rt, x.rd, x.sh, 'h02);
      K_SRA:   return ri(0, x.rt, x.rd, x.sh, 'h03);
      K_ADDI:  return ii('h08, x.rs, x.rt, x.imm);
      K_ADDIU: return ii('h09, x.rs, x.rt, x.imm);
      K_SLTI:  return ii('h0A, x.rs, x.rt, x.imm);
      K_ANDI:  return ii('h0C, x.rs, x.rt, x.imm);
      K_ORI:   return ii('h0D, x.rs, x.rt, x.imm);
      K_XORI:  return ii('h0E, x.rs, x.rt, x.imm);
      K_LUI:   return ii('h0F, 0, x.rt, x.imm);
      K_LW:    return ii('h23, x.rs, x.rt, x.imm);
      default: return ii('h2B, x.rs, x.rt, x.imm);
    endcase
  endfunction

  function automatic logic fits32(input longint s);
    return (s <= 64'sd2147483647) && (s >= -64'sd2147483648);
  endfunction

  task automatic mstep(input rin_t x, output logic ovf);
    logic [31:0] a, b, r, zimm, ad;
    longint      sa, sb, si, s;
    int          dst;
    a    = mreg[x.rs];
    b    = mreg[x.rt];
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    si   = longint'(x.imm);
    zimm = 32'(x.imm) & 32'h0000FFFF;
    ad   = a + 32'(x.imm);
    ovf  = 1'b0;
    r    = '0;
    dst  = x.rd;
    case (x.k)
      K_ADD:   begin s = sa + sb; ovf = !fits32(s); r = s[31:0]; end
      K_ADDU:  r = a + b;
      K_SUB:   begin s = sa - sb; ovf = !fits32(s); r = s[31:0]; end
      K_SUBU:  r = a - b;
      K_AND:   r = a & b;
      K_OR:    r = a | b;
      K_XOR:   r = a ^ b;
      K_NOR:   r = ~(a | b);
      K_SLT:   r = {31'd0, sa < sb};
      K_SLTU:  r = {31'd0, a < b};
      K_SLL:   r = b << x.sh;
      K_SRL:   r = b >> x.sh;
      K_SRA:   begin s = sb >>> x.sh; r = s[31:0]; end
      K_ADDI:  begin s = sa + si; ovf = !fits32(s); r = s[31:0]; dst = x.rt; end
      K_ADDIU: begin r = ad; dst = x.rt; end
      K_SLTI:  begin r = {31'd0, sa < si}; dst = x.rt; end
      K_ANDI:  begin r = a & zimm; dst = x.rt; end
      K_ORI:   begin r = a | zimm; dst = x.rt; end
      K_XORI:  begin r = a ^ zimm; dst = x.rt; end
      K_LUI:   begin r = zimm * 32'd65536; dst = x.rt; end
      K_LW:    begin r = mdm[(ad / 4) % 256]; dst = x.rt; end
      default: begin mdm[(ad / 4) % 256] = b; dst = 0; end
    endcase
    if (dst != 0) mreg[dst] = r;
  endtask

  // ---------------- main ----------------
  initial begin
    reset = 1'b0;

    // Test 1: branches, j, andi, overflow
    prog.delete();
    prog.push_back(ii('h08, 0, 8, -1));      //   0 addi t0,$0,-1
    prog.push_back(32'h0);                   //   4
    prog.push_back(ii('h01, 8, 1, 1));       //   8 bgez t0,+1 (not taken)
    prog.push_back(ji('h02, 5));             //  12 j 5
    prog.push_back(ii('h08, 0, 13, 99));     //  16 skipped
    prog.push_back(ii('h08, 0, 9, 0));       //  20 addi t1,$0,0
    prog.push_back(ii('h01, 9, 1, 1));       //  24 bgez t1,+1
    prog.push_back(ii('h08, 0, 13, 1));      //  28 skipped
    prog.push_back(ii('h08, 0, 11, 1));      //  32 addi t3,$0,1
    prog.push_back(32'h0);                   //  36
    prog.push_back(ii('h01, 11, 1, 1));      //  40 bgez t3,+1
    prog.push_back(ii('h08, 0, 13, 2));      //  44 skipped
    prog.push_back(ii('h08, 0, 10, 5));      //  48 addi t2,$0,5
    prog.push_back(ii('h0C, 10, 11, 6));     //  52 andi t3,t2,6
    prog.push_back(32'h0);                   //  56
    prog.push_back(32'h0);                   //  60
    prog.push_back(ii('h08, 0, 8, 1));       //  64 addi t0,$0,1
    prog.push_back(ii('h06, 8, 0, 1));       //  68 blez t0 (not taken)
    prog.push_back(ii('h08, 0, 9, 0));       //  72
    prog.push_back(32'h0);                   //  76
    prog.push_back(32'h0);                   //  80
    prog.push_back(ii('h06, 9, 0, 1));       //  84 blez t1 (taken)
    prog.push_back(ii('h08, 0, 13, 3));      //  88 skipped
    prog.push_back(ii('h08, 0, 11, -1));     //  92 addi t3,$0,-1
    prog.push_back(32'h0);                   //  96
    prog.push_back(ii('h06, 11, 0, 1));      // 100 blez t3 (taken)
    prog.push_back(ii('h08, 0, 13, 4));      // 104 skipped
    prog.push_back(ii('h08, 0, 8, 'h7FFF));  // 108 addi t0,$0,0x7FFF
    prog.push_back(ii('h0F, 0, 9, 'h7FFF));  // 112 lui t1,0x7FFF
    prog.push_back(ri(9, 9, 10, 0, 'h20));   // 116 add t2,t1,t1
    prog.push_back(ii('h08, 0, 16, 512));    // 120 addi s0,$0,512
    prog.push_back(ji('h02, 31));            // 124 j self

    vecs.delete();
    av(0, 0, 0, 0);    av(4, 0, 8, 32'hFFFFFFFF); av(8, 0, 0, 0);   av(12, 0, 0, 0);
    av(20, 0, 0, 0);   av(24, 0, 9, 0);           av(32, 0, 0, 0);  av(36, 0, 0, 0);
    av(40, 0, 11, 1);  av(48, 0, 0, 0);           av(52, 0, 10, 5); av(56, 0, 0, 0);
    av(60, 0, 11, 4);  av(64, 0, 0, 0);           av(68, 0, 8, 1);  av(72, 0, 0, 0);
    av(76, 0, 0, 0);   av(80, 0, 0, 0);           av(84, 0, 0, 0);  av(92, 0, 0, 0);
    av(96, 0, 0, 0);   av(100, 0, 11, 32'hFFFFFFFF); av(108, 0, 0, 0);
    av(112, 0, 8, 32'h00007FFF); av(116, 1, 9, 32'h7FFF0000);
    av(120, 0, 10, 32'hFFFE0000); av(124, 0, 16, 512); av(124, 0, 13, 0);

    load_prog();
    run_vecs("prog1");
    check("t3_after_andi", dut.b2v_rf.contents_t3, 32'hFFFFFFFF);

    // Asynchronous reset mid-run, away from any clock edge
    #2 reset = 1'b0;
    #1;
    check("rst_pc_async", PC, 32'd0);
    begin
      logic [31:0] acc;
      acc = '0;
      for (int i = 0; i < 32; i++) acc |= dut.b2v_rf.regs[i];
      check("rst_regs_or", acc, 32'd0);
    end
    check("rst_contents_s0", dut.b2v_rf.contents_s0, 32'd0);
    check("rst_opcode", {26'd0, OPCODE}, 32'h8);
    @(posedge clk); #1;
    check("rst_hold_pc", PC, 32'd0);
    check("rst_hold_t0", dut.b2v_rf.contents_t0, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    check("rst_release_pc", PC, 32'd4);
    check("rst_release_t0", dut.b2v_rf.contents_t0, 32'hFFFFFFFF);

    // Test 2: jal/jr, bltz/bgtz/beq/bne, unknown opcode
    prog.delete();
    prog.push_back(ji('h03, 4));             //  0 jal 16
    prog.push_back(32'hFC000000);            //  4 unknown opcode
    prog.push_back(ji('h02, 2));             //  8 j self
    prog.push_back(32'h0);                   // 12
    prog.push_back(ii('h08, 0, 8, -3));      // 16 addi t0,$0,-3
    prog.push_back(ii('h01, 8, 0, 1));       // 20 bltz t0 (taken)
    prog.push_back(ii('h08, 0, 13, 1));      // 24 skipped
    prog.push_back(ii('h07, 8, 0, 1));       // 28 bgtz t0 (not taken)
    prog.push_back(ii('h04, 8, 8, 1));       // 32 beq t0,t0 (taken)
    prog.push_back(ii('h08, 0, 13, 2));      // 36 skipped
    prog.push_back(ii('h05, 8, 0, 1));       // 40 bne t0,$0 (taken)
    prog.push_back(32'h0);                   // 44 skipped
    prog.push_back(ri(31, 0, 0, 0, 'h08));   // 48 jr ra
    vecs.delete();
    av(0, 0, 0, 0);  av(16, 0, 31, 4); av(20, 0, 8, 32'hFFFFFFFD); av(28, 0, 0, 0);
    av(32, 0, 0, 0); av(40, 0, 0, 0);  av(48, 0, 0, 0);            av(4, 0, 0, 0);
    av(8, 0, 0, 0);  av(8, 0, 13, 0);
    load_prog();
    run_vecs("prog2");

    // Test 3: instruction memory index wraps past the top word
    prog.delete();
    prog.push_back(ji('h02, 255));
    for (int i = 1; i < 255; i++) prog.push_back(32'h0);
    prog.push_back(ii('h08, 0, 8, 7));
    vecs.delete();
    av(0, 0, 0, 0); av(1020, 0, 0, 0); av(1024, 0, 8, 7); av(1020, 0, 0, 0);
    load_prog();
    run_vecs("wrap");

    // Test 4: random straight-line programs against the reference model
    for (int round = 0; round < 2; round++) begin
      int addrs[$];
      rq.delete();
      for (int r = 1; r < 16; r++) begin
        rin_t x;
        x = '{k: K_LUI, rs: 0, rt: r, rd: 0, sh: 0, imm: int'($urandom_range(0, 65535))};
        rq.push_back(x);
        x = '{k: K_ORI, rs: r, rt: r, rd: 0, sh: 0, imm: int'($urandom_range(0, 65535))};
        rq.push_back(x);
      end
      for (int n = 0; n < 60; n++) begin
        rin_t x;
        x.k   = kind_t'($urandom_range(0, 21));
        x.rs  = int'($urandom_range(0, 15));
        x.rt  = int'($urandom_range(0, 15));
        x.rd  = int'($urandom_range(0, 15));
        x.sh  = int'($urandom_range(0, 31));
        x.imm = int'($urandom_range(0, 65535)) - 32768;
        if (x.k == K_LW && addrs.size() == 0) x.k = K_SW;
        if (x.k == K_SW) begin
          x.rs  = 0;
          x.imm = 4 * int'($urandom_range(0, 8191));
          addrs.push_back(x.imm);
        end else if (x.k == K_LW) begin
          x.rs  = 0;
          x.imm = addrs[$urandom_range(0, addrs.size() - 1)];
        end
        rq.push_back(x);
      end
      prog.delete();
      foreach (rq[i]) prog.push_back(enc(rq[i]));
      prog.push_back(ji('h02, rq.size()));
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      load_prog();
      for (int i = 0; i < rq.size(); i++) begin
        logic movf;
        mstep(rq[i], movf);
        check($sformatf("rnd%0d pc[%0d]", round, i), PC, 32'(4 * i));
        check($sformatf("rnd%0d ovf[%0d]", round, i), {31'd0, Overflow}, {31'd0, movf});
        @(negedge clk); #1;
      end
      for (int i = 0; i < 32; i++)
        check($sformatf("rnd%0d reg[%0d]", round, i), dut.b2v_rf.regs[i], mreg[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
